// File: rtl/aclk_counter.sv
// aclk_counter: current-time keeper for the alarm clock.
// Holds HH:MM as four BCD digits in 24-hour form. It advances on minute
// strobes, blinks the colon on second strobes, and accepts validated loads.
// It also pulses day_wrap on the 23:59 -> 00:00 roll-over.
module aclk_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        one_minute,
    input  logic        one_second,
    input  logic        load_new_c,
    input  logic [15:0] new_current_time,
    output logic [15:0] current_time,
    output logic        colon,
    output logic        day_wrap,
    output logic        load_err
);

    // A loaded time is accepted only if every digit is legal BCD for its
    // position and the hour does not exceed 23.
    function automatic logic time_valid(input logic [15:0] t);
        logic [3:0] ht, ho, mt, mo;
        ht = t[15:12];
        ho = t[11:8];
        mt = t[7:4];
        mo = t[3:0];
        time_valid = (ht <= 4'd2) && (ho <= 4'd9) && (mt <= 4'd5) &&
                     (mo <= 4'd9) && ((ht != 4'd2) || (ho <= 4'd3));
    endfunction

    // One-minute BCD cascade. Returns {wrap, next_time}. The whole carry
    // chain resolves in one step, so no intermediate digit value is ever
    // registered.
    function automatic logic [16:0] advance_minute(input logic [15:0] t);
        logic [3:0] ht, ho, mt, mo;
        logic       wrap;
        ht   = t[15:12];
        ho   = t[11:8];
        mt   = t[7:4];
        mo   = t[3:0];
        wrap = 1'b0;
        if (mo != 4'd9) begin
            mo = mo + 4'd1;
        end else begin
            mo = 4'd0;
            if (mt != 4'd5) begin
                mt = mt + 4'd1;
            end else begin
                mt = 4'd0;
                if ((ht == 4'd2) && (ho == 4'd3)) begin
                    ht   = 4'd0;
                    ho   = 4'd0;
                    wrap = 1'b1;
                end else if (ho == 4'd9) begin
                    ho = 4'd0;
                    ht = ht + 4'd1;
                end else begin
                    ho = ho + 4'd1;
                end
            end
        end
        advance_minute = {wrap, ht, ho, mt, mo};
    endfunction

    logic [15:0] time_nxt;
    logic        colon_nxt;
    logic        wrap_nxt;
    logic        err_nxt;
    logic [16:0] adv;

    assign adv = advance_minute(current_time);

    // Next-state selection with priority load > minute advance. A minute
    // strobe that arrives with a load is dropped, not deferred.
    always_comb begin
        time_nxt  = current_time;
        colon_nxt = one_second ? ~colon : colon;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (load_new_c) begin
            if (time_valid(new_current_time)) begin
                time_nxt  = new_current_time;
                colon_nxt = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (one_minute) begin
            time_nxt = adv[15:0];
            wrap_nxt = adv[16];
        end
    end

    // Output registers; day_wrap and load_err are single-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_time <= 16'h0000;
            colon        <= 1'b1;
            day_wrap     <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            current_time <= time_nxt;
            colon        <= colon_nxt;
            day_wrap     <= wrap_nxt;
            load_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_aclk_counter.sv
// tb_aclk_counter: directed bench for aclk_counter with a minutes-of-day
// reference model feeding an expected-result queue.
module tb_aclk_counter;

    logic        clk;
    logic        reset;
    logic        one_minute;
    logic        one_second;
    logic        load_new_c;
    logic [15:0] new_current_time;
    logic [15:0] current_time;
    logic        colon;
    logic        day_wrap;
    logic        load_err;

    aclk_counter dut (
        .clk              (clk),
        .reset            (reset),
        .one_minute       (one_minute),
        .one_second       (one_second),
        .load_new_c       (load_new_c),
        .new_current_time (new_current_time),
        .current_time     (current_time),
        .colon            (colon),
        .day_wrap         (day_wrap),
        .load_err         (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] t;
        logic        c;
        logic        w;
        logic        e;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_mins;
    logic m_colon;
    int   wrap_seen;

    function automatic logic [15:0] to_bcd(input int mins);
        int h, m;
        logic [3:0] d3, d2, d1, d0;
        h  = mins / 60;
        m  = mins % 60;
        d3 = 4'(h / 10);
        d2 = 4'(h % 10);
        d1 = 4'(m / 10);
        d0 = 4'(m % 10);
        return {d3, d2, d1, d0};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict the result, compare after the edge.
    task automatic step(input logic lc, input logic [15:0] nt, input logic om,
                        input logic os, input string tag);
        exp_t e;
        int ht, ho, mt, mo;
        bit valid;
        @(negedge clk);
        load_new_c       = lc;
        new_current_time = nt;
        one_minute       = om;
        one_second       = os;
        ht = int'(nt[15:12]);
        ho = int'(nt[11:8]);
        mt = int'(nt[7:4]);
        mo = int'(nt[3:0]);
        valid = (ht * 10 + ho < 24) && (ho <= 9) && (mt <= 5) && (mo <= 9);
        e.w = 1'b0;
        e.e = 1'b0;
        if (lc) begin
            if (valid) begin
                m_mins  = (ht * 10 + ho) * 60 + mt * 10 + mo;
                m_colon = 1'b1;
            end else begin
                e.e = 1'b1;
                if (os) m_colon = ~m_colon;
            end
        end else begin
            if (om) begin
                m_mins++;
                if (m_mins == 1440) begin
                    m_mins = 0;
                    e.w    = 1'b1;
                end
            end
            if (os) m_colon = ~m_colon;
        end
        e.t   = to_bcd(m_mins);
        e.c   = m_colon;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check({e.tag, ".time"},  current_time,    e.t);
        check({e.tag, ".colon"}, 16'(colon),      16'(e.c));
        check({e.tag, ".wrap"},  16'(day_wrap),   16'(e.w));
        check({e.tag, ".err"},   16'(load_err),   16'(e.e));
        if (day_wrap) wrap_seen++;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".time"},  current_time,  16'h0000);
        check({tag, ".colon"}, 16'(colon),    16'h0001);
        check({tag, ".wrap"},  16'(day_wrap), 16'h0000);
        check({tag, ".err"},   16'(load_err), 16'h0000);
    endtask

    initial begin
        reset            = 1'b1;
        one_minute       = 1'b0;
        one_second       = 1'b0;
        load_new_c       = 1'b0;
        new_current_time = 16'h0000;
        m_mins           = 0;
        m_colon          = 1'b1;
        wrap_seen        = 0;
        #2;
        check_reset_state("rst_init");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // minute cascade
        step(1'b1, 16'h0959, 1'b0, 1'b0, "ld0959");
        step(1'b0, 16'h0000, 1'b1, 1'b0, "casc1000");
        step(1'b1, 16'h1959, 1'b0, 1'b0, "ld1959");
        step(1'b0, 16'h0000, 1'b1, 1'b0, "casc2000");
        step(1'b1, 16'h0009, 1'b0, 1'b0, "ld0009");
        step(1'b0, 16'h0000, 1'b1, 1'b0, "casc0010");

        // day roll-over
        step(1'b1, 16'h2359, 1'b0, 1'b0, "ld2359");
        step(1'b0, 16'h0000, 1'b1, 1'b0, "roll");
        step(1'b0, 16'h0000, 1'b0, 1'b0, "roll_after");
        step(1'b1, 16'h0000, 1'b0, 1'b0, "ld0000");

        // load validation
        step(1'b1, 16'h1111, 1'b0, 1'b0, "ld1111");
        step(1'b1, 16'h2400, 1'b0, 1'b0, "bad2400");
        step(1'b1, 16'h1960, 1'b0, 1'b0, "bad1960");
        step(1'b1, 16'h2A00, 1'b0, 1'b0, "bad2A00");
        step(1'b1, 16'h1A00, 1'b0, 1'b0, "bad1A00");
        step(1'b1, 16'h3000, 1'b0, 1'b0, "bad3000");
        step(1'b1, 16'h005A, 1'b0, 1'b0, "bad005A");
        step(1'b0, 16'h0000, 1'b0, 1'b0, "err_clear");
        step(1'b1, 16'h2345, 1'b0, 1'b0, "ld2345");

        // simultaneous events
        step(1'b1, 16'h1000, 1'b1, 1'b0, "ld_om");
        step(1'b0, 16'h0000, 1'b0, 1'b1, "sec_tog");
        step(1'b1, 16'h1200, 1'b0, 1'b1, "ld_os");
        step(1'b0, 16'h0000, 1'b0, 1'b1, "sec_tog2");
        step(1'b1, 16'h2500, 1'b1, 1'b1, "bad_os_om");

        // back-to-back loads, then hold
        step(1'b1, 16'h0100, 1'b0, 1'b0, "b2b_a");
        step(1'b1, 16'h0200, 1'b0, 1'b0, "b2b_b");
        step(1'b0, 16'h0000, 1'b0, 1'b0, "hold1");
        step(1'b0, 16'h0000, 1'b0, 1'b0, "hold2");

        // asynchronous reset mid-count at 12:34
        step(1'b1, 16'h1233, 1'b0, 1'b0, "ld1233");
        step(1'b0, 16'h0000, 1'b1, 1'b1, "to1234");
        @(negedge clk);
        one_minute = 1'b1;
        one_second = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("rst_async");
        @(posedge clk);
        #1;
        check_reset_state("rst_held");
        @(negedge clk);
        reset      = 1'b0;
        one_minute = 1'b0;
        one_second = 1'b0;
        m_mins     = 0;
        m_colon    = 1'b1;
        step(1'b0, 16'h0000, 1'b1, 1'b0, "post_rst");

        // full-day stream: back-to-back minute strobes from 00:00
        step(1'b1, 16'h0000, 1'b0, 1'b0, "stream_ld");
        wrap_seen = 0;
        for (int i = 0; i < 1440; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'($urandom_range(0, 1)), "stream");
        end
        check("stream_final", current_time, 16'h0000);
        check("stream_wraps", 16'(wrap_seen), 16'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, "stream_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
